// File: rtl/snes_cast_pkg.sv
// Shared types and constants for the SNES bus event framer.
// Holds the record layout, event kinds and the framer state encoding.
package snes_cast_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] KIND_WR = 2'b01;
    localparam logic [1:0] KIND_RD = 2'b10;

    localparam int EVENT_W = 18;

    localparam int HDR_SEQ_LSB  = 4;
    localparam int HDR_LOST_BIT = 3;
    localparam int HDR_KIND_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        ADDR,
        DATA,
        CSUM
    } state_t;

    function automatic logic [7:0] make_header(input logic [3:0] seq,
                                               input logic       lost,
                                               input logic [1:0] kind);
        logic [7:0] h;
        h = 8'h00;
        h[HDR_SEQ_LSB +: 4] = seq;
        h[HDR_LOST_BIT]     = lost;
        h[HDR_KIND_LSB +: 2] = kind;
        return h;
    endfunction

endpackage

// File: rtl/snes_event_framer_if.sv
// Capture-event input and crossfifo write-port bundle for the framer.
// master is the framer side; slave is the capture stage plus FIFO side.
interface snes_event_framer_if;

    logic       ev_valid;
    logic [1:0] ev_kind;
    logic [7:0] ev_addr;
    logic [7:0] ev_data;
    logic [7:0] fifo_data;
    logic       fifo_wrreq;
    logic       fifo_wrfull;

    modport master (
        input  ev_valid, ev_kind, ev_addr, ev_data, fifo_wrfull,
        output fifo_data, fifo_wrreq
    );

    modport slave (
        output ev_valid, ev_kind, ev_addr, ev_data, fifo_wrfull,
        input  fifo_data, fifo_wrreq
    );

endinterface

// File: rtl/snes_event_queue.sv
// Small first-word-fall-through event FIFO absorbing crossfifo backpressure.
// A push alongside a pop is taken even when the queue is full.
module snes_event_queue
    import snes_cast_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [EVENT_W-1:0] din,
    output logic [EVENT_W-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int AW = $clog2(QDEPTH);

    logic [EVENT_W-1:0] mem [QDEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The extra pointer bit separates the full and empty cases when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/snes_event_framer.sv
// Frames filtered SNES bus events into 5-byte records for the USB crossfifo.
// Tracks sequence numbers, loss flags and a saturating drop count.
module snes_event_framer
    import snes_cast_pkg::*;
#(
    parameter int         QDEPTH    = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    snes_event_framer_if.master        bus,
    input  logic                       filt_en,
    input  logic [7:0]                 filt_lo,
    input  logic [7:0]                 filt_hi,
    output logic [15:0]                drop_count,
    output logic                       busy
);

    state_t             state;
    state_t             state_next;
    logic               in_window;
    logic               accept;
    logic               drop;
    logic               load;
    logic               wrreq;
    logic               q_push;
    logic               q_empty;
    logic               q_full;
    logic [EVENT_W-1:0] q_din;
    logic [EVENT_W-1:0] q_dout;
    logic [1:0]         rec_kind;
    logic [7:0]         rec_addr;
    logic [7:0]         rec_data;
    logic               rec_lost;
    logic               lost_pend;
    logic [3:0]         seq;
    logic [7:0]         header;
    logic [7:0]         csum;
    logic [7:0]         byte_mux;

    // An inverted window (lo > hi) can never satisfy both bounds, so it rejects everything.
    assign in_window = (filt_lo <= bus.ev_addr) && (bus.ev_addr <= filt_hi);
    assign accept    = bus.ev_valid && (bus.ev_kind == KIND_WR || bus.ev_kind == KIND_RD)
                       && (!filt_en || in_window);
    assign q_push    = accept && (!q_full || load);
    assign drop      = accept && q_full && !load;
    assign q_din     = {bus.ev_kind, bus.ev_addr, bus.ev_data};

    snes_event_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (load),
        .din   (q_din),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full)
    );

    assign header         = make_header(seq, rec_lost, rec_kind);
    assign csum           = header ^ rec_addr ^ rec_data;
    assign wrreq          = (state != IDLE) && !bus.fifo_wrfull;
    assign bus.fifo_wrreq = wrreq;
    assign bus.fifo_data  = byte_mux;
    assign busy           = (state != IDLE) || !q_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        byte_mux   = 8'h00;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    load       = 1'b1;
                    state_next = SYNC;
                end
            end
            SYNC: begin
                byte_mux = SYNC_BYTE;
                if (wrreq) state_next = HDR;
            end
            HDR: begin
                byte_mux = header;
                if (wrreq) state_next = ADDR;
            end
            ADDR: begin
                byte_mux = rec_addr;
                if (wrreq) state_next = DATA;
            end
            DATA: begin
                byte_mux = rec_data;
                if (wrreq) state_next = CSUM;
            end
            CSUM: begin
                byte_mux = csum;
                // Chain straight into the next record so back-to-back records have no gap.
                if (wrreq) begin
                    if (!q_empty) begin
                        load       = 1'b1;
                        state_next = SYNC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_kind <= 2'b00;
            rec_addr <= 8'h00;
            rec_data <= 8'h00;
            rec_lost <= 1'b0;
        end else if (load) begin
            {rec_kind, rec_addr, rec_data} <= q_dout;
            rec_lost                       <= lost_pend;
        end
    end

    // A drop coinciding with a load wins, so that loss is reported on the following record.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_pend  <= 1'b0;
            drop_count <= 16'h0000;
            seq        <= 4'h0;
        end else begin
            if (drop)      lost_pend <= 1'b1;
            else if (load) lost_pend <= 1'b0;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (state == CSUM && wrreq) seq <= seq + 4'd1;
        end
    end

endmodule

// File: tb/tb_snes_event_framer.sv
// Scoreboard bench for snes_event_framer: a byte-stream model predicts every
// framed byte, the drop count and busy; a negedge monitor compares them.
module tb_snes_event_framer;
    import snes_cast_pkg::*;

    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        filt_en;
    logic [7:0]  filt_lo;
    logic [7:0]  filt_hi;
    logic [15:0] drop_count;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    snes_event_framer_if bus ();

    snes_event_framer #(.QDEPTH(QDEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .filt_en    (filt_en),
        .filt_lo    (filt_lo),
        .filt_hi    (filt_hi),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending events, bytes left in the record being sent, expected byte stream.
    logic [17:0] mq [$];
    logic [7:0]  exp_bytes [$];
    int          m_left = 0;
    int          rec_idx = 0;
    bit          lost_flag = 1'b0;
    int          m_drops = 0;
    bit          m_wr;
    bit          m_pop;
    bit          m_acc;
    logic [17:0] m_ev;
    logic [7:0]  m_hdr;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_bytes.delete();
            m_left    = 0;
            rec_idx   = 0;
            lost_flag = 1'b0;
            m_drops   = 0;
        end else begin
            m_wr  = (m_left > 0) && !bus.fifo_wrfull;
            m_pop = (mq.size() > 0) && (m_left == 0 || (m_left == 1 && m_wr));
            m_acc = bus.ev_valid && (bus.ev_kind == 2'b01 || bus.ev_kind == 2'b10)
                    && (!filt_en || (bus.ev_addr >= filt_lo && bus.ev_addr <= filt_hi));
            if (m_wr) m_left--;
            if (m_pop) begin
                m_ev  = mq.pop_front();
                m_hdr = {rec_idx[3:0], lost_flag, 1'b0, m_ev[17:16]};
                exp_bytes.push_back(8'hA5);
                exp_bytes.push_back(m_hdr);
                exp_bytes.push_back(m_ev[15:8]);
                exp_bytes.push_back(m_ev[7:0]);
                exp_bytes.push_back(m_hdr ^ m_ev[15:8] ^ m_ev[7:0]);
                rec_idx++;
                m_left    = 5;
                lost_flag = 1'b0;
            end
            if (m_acc) begin
                if (mq.size() < QDEPTH) begin
                    mq.push_back({bus.ev_kind, bus.ev_addr, bus.ev_data});
                end else begin
                    lost_flag = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !rst) begin
            check_output("wrreq", bus.fifo_wrreq, (m_left > 0) && !bus.fifo_wrfull);
            check_output("busy", busy, (m_left > 0) || (mq.size() > 0));
            check_output("drop_count", drop_count, m_drops);
            if (m_left == 0) check_output("idle_data", bus.fifo_data, 8'h00);
            if (bus.fifo_wrreq) begin
                if (exp_bytes.size() == 0) begin
                    check_output("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    check_output("byte", bus.fifo_data, exp_bytes.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic apply_stimulus(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
        bus.ev_valid = 1'b1;
        bus.ev_kind  = kind;
        bus.ev_addr  = addr;
        bus.ev_data  = data;
        cycle();
        bus.ev_valid = 1'b0;
    endtask

    logic [7:0] win_addrs [4];

    initial begin
        bus.ev_valid    = 1'b0;
        bus.ev_kind     = 2'b00;
        bus.ev_addr     = 8'h00;
        bus.ev_data     = 8'h00;
        bus.fifo_wrfull = 1'b0;
        filt_en         = 1'b0;
        filt_lo         = 8'h00;
        filt_hi         = 8'hFF;
        rst             = 1'b1;
        idle(3);
        rst      = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check_output("reset_wrreq", bus.fifo_wrreq, 1'b0);
        check_output("reset_data", bus.fifo_data, 8'h00);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_drops", drop_count, 16'h0000);
        cycle();

        // Single write: A5 01 21 80 A0.
        idle(5);
        apply_stimulus(KIND_WR, 8'h21, 8'h80);
        idle(10);

        // Ignored kinds.
        apply_stimulus(2'b00, 8'h10, 8'h11);
        apply_stimulus(2'b11, 8'h12, 8'h13);
        idle(3);

        // Address window 40..43.
        filt_en = 1'b1;
        filt_lo = 8'h40;
        filt_hi = 8'h43;
        win_addrs[0] = 8'h3F;
        win_addrs[1] = 8'h40;
        win_addrs[2] = 8'h43;
        win_addrs[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(KIND_RD, win_addrs[i], 8'($urandom));
            idle(7);
        end

        // Inverted window rejects all.
        filt_lo = 8'h50;
        filt_hi = 8'h40;
        for (int i = 0; i < 3; i++) apply_stimulus(KIND_WR, 8'h45 + 8'(i), 8'($urandom));
        idle(5);
        filt_en = 1'b0;

        // Stall for 7 cycles while the header byte is presented.
        apply_stimulus(KIND_WR, 8'($urandom), 8'($urandom));
        idle(2);
        bus.fifo_wrfull = 1'b1;
        idle(7);
        bus.fifo_wrfull = 1'b0;
        idle(10);

        // Overflow: 7 accepted events against a full FIFO.
        bus.fifo_wrfull = 1'b1;
        for (int i = 0; i < 7; i++) apply_stimulus(2'(1 + (i % 2)), 8'($urandom), 8'($urandom));
        @(negedge clk);
        check_output("overflow_drops", drop_count, 16'd2);
        cycle();
        bus.fifo_wrfull = 1'b0;
        idle(40);

        // Randomised traffic with random backpressure and window settings.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                filt_en = 1'($urandom_range(0, 1));
                filt_lo = 8'($urandom);
                filt_hi = 8'($urandom);
            end
            bus.fifo_wrfull = ($urandom_range(0, 3) == 0);
            bus.ev_valid    = ($urandom_range(0, 2) == 0);
            bus.ev_kind     = 2'($urandom);
            bus.ev_addr     = 8'($urandom);
            bus.ev_data     = 8'($urandom);
            cycle();
        end
        bus.ev_valid    = 1'b0;
        bus.fifo_wrfull = 1'b0;
        filt_en         = 1'b0;
        idle(40);

        // 17 back-to-back records to wrap the sequence number.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(KIND_RD, 8'($urandom), 8'($urandom));
            idle(4);
        end
        idle(10);

        // Reset while the address byte is presented.
        apply_stimulus(KIND_WR, 8'h33, 8'h44);
        idle(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_mid_wrreq", bus.fifo_wrreq, 1'b0);
        check_output("rst_mid_busy", busy, 1'b0);
        cycle();
        apply_stimulus(KIND_WR, 8'h55, 8'h66);
        idle(10);

        // Force the drop counter past saturation.
        bus.fifo_wrfull = 1'b1;
        bus.ev_valid    = 1'b1;
        bus.ev_kind     = KIND_WR;
        for (int i = 0; i < 65545; i++) begin
            bus.ev_addr = 8'(i);
            bus.ev_data = 8'(i >> 8);
            cycle();
        end
        bus.ev_valid = 1'b0;
        @(negedge clk);
        check_output("drop_saturate", drop_count, 16'hFFFF);
        cycle();
        bus.fifo_wrfull = 1'b0;
        idle(40);

        check_output("stream_drained", exp_bytes.size(), 0);
        check_output("queue_drained", mq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
